// File: rtl/niosv_soc_gpi_event_poller.sv
`default_nettype none
// ============================================================================
// Module   : niosv_soc_gpi_event_poller
// Brief    : Polls a GPI edge-capture register, clears the captured bits and
//            queues {edges, level} events in a show-ahead FIFO with an irq.
// Revision : 1.0 - initial release
// ============================================================================
module niosv_soc_gpi_event_poller #(
    parameter int W          = 4,
    parameter int POLL_DIV   = 1000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          irq_en,
    output logic [1:0]                    pio_address,
    output logic                          pio_chipselect,
    output logic                          pio_write_n,
    output logic [31:0]                   pio_writedata,
    input  logic [31:0]                   pio_readdata,
    input  logic                          evt_pop,
    output logic                          evt_valid,
    output logic [W-1:0]                  evt_edges,
    output logic [W-1:0]                  evt_level,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic                          irq,
    output logic                          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(POLL_DIV);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RD_EDGE   = 3'd1,
        S_WAIT_EDGE = 3'd2,
        S_CLR       = 3'd3,
        S_RD_DATA   = 3'd4,
        S_WAIT_DATA = 3'd5,
        S_PUSH      = 3'd6
    } state_t;

    state_t         state, state_next;
    logic [TW-1:0]  timer;
    logic [W-1:0]   edges, level;
    logic           poll_start;

    logic [W-1:0]   mem_edges [FIFO_DEPTH];
    logic [W-1:0]   mem_level [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           full, push_req, push_ok, pop_ok;

    // Only the low W bits of the slave data carry GPI state.
    logic           unused_readdata;
    assign unused_readdata = ^pio_readdata;

    assign poll_start = (timer == '0) && (state == S_IDLE) && enable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= TW'(POLL_DIV - 1);
        end else if (timer == '0) begin
            timer <= TW'(POLL_DIV - 1);
        end else begin
            timer <= timer - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            edges <= '0;
            level <= '0;
        end else begin
            state <= state_next;
            if (state == S_WAIT_EDGE) edges <= pio_readdata[W-1:0];
            if (state == S_WAIT_DATA) level <= pio_readdata[W-1:0];
        end
    end

    // Bus strobes decode straight from state so an async reset drops them at once.
    always_comb begin
        state_next     = state;
        pio_address    = 2'd0;
        pio_chipselect = 1'b0;
        pio_write_n    = 1'b1;
        pio_writedata  = '0;
        case (state)
            S_IDLE: begin
                if (poll_start) state_next = S_RD_EDGE;
            end
            S_RD_EDGE: begin
                pio_address    = 2'd3;
                pio_chipselect = 1'b1;
                state_next     = S_WAIT_EDGE;
            end
            S_WAIT_EDGE: begin
                state_next = (pio_readdata[W-1:0] == '0) ? S_IDLE : S_CLR;
            end
            S_CLR: begin
                pio_address           = 2'd3;
                pio_chipselect        = 1'b1;
                pio_write_n           = 1'b0;
                pio_writedata[W-1:0]  = edges;
                state_next            = S_RD_DATA;
            end
            S_RD_DATA: begin
                pio_address    = 2'd0;
                pio_chipselect = 1'b1;
                state_next     = S_WAIT_DATA;
            end
            S_WAIT_DATA: state_next = S_PUSH;
            S_PUSH:      state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    assign full     = (count == CW'(FIFO_DEPTH));
    assign push_req = (state == S_PUSH);
    assign pop_ok   = evt_pop && (count != '0);
    assign push_ok  = push_req && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_edges[wr_ptr] <= edges;
            mem_level[wr_ptr] <= level;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && full && !pop_ok) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign evt_valid = (count != '0);
    assign evt_edges = evt_valid ? mem_edges[rd_ptr] : '0;
    assign evt_level = evt_valid ? mem_level[rd_ptr] : '0;
    assign evt_count = count;
    assign irq       = evt_valid & irq_en;
    assign busy      = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_niosv_soc_gpi_event_poller.sv
`default_nettype none
// ============================================================================
// Module   : tb_niosv_soc_gpi_event_poller
// Brief    : Bench with a behavioural edge-capturing GPI slave and an event
//            scoreboard for niosv_soc_gpi_event_poller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_niosv_soc_gpi_event_poller;

    localparam int W          = 4;
    localparam int POLL_DIV   = 16;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, enable, irq_en, evt_pop, ovf_clr;
    logic [1:0]  pio_address;
    logic        pio_chipselect, pio_write_n;
    logic [31:0] pio_writedata;
    logic [31:0] pio_readdata = '0;
    logic        evt_valid, overflow, irq, busy;
    logic [W-1:0] evt_edges, evt_level;
    logic [2:0]  evt_count;

    niosv_soc_gpi_event_poller #(.W(W), .POLL_DIV(POLL_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .reset(reset), .enable(enable), .irq_en(irq_en),
        .pio_address(pio_address), .pio_chipselect(pio_chipselect),
        .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
        .pio_readdata(pio_readdata), .evt_pop(evt_pop), .evt_valid(evt_valid),
        .evt_edges(evt_edges), .evt_level(evt_level), .evt_count(evt_count),
        .overflow(overflow), .ovf_clr(ovf_clr), .irq(irq), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural GPI: any-edge capture, write-1-to-clear with clear priority.
    logic [3:0]  in_port = '0;
    logic [3:0]  prev_in = '0;
    logic [3:0]  capture = '0;
    logic [31:0] last_wd = '0;
    int          n_writes = 0, n_edge_rd = 0, n_data_rd = 0;

    always @(posedge clk) begin
        prev_in <= in_port;
        capture <= (capture | (prev_in ^ in_port)) &
                   ~((pio_chipselect && !pio_write_n && pio_address == 2'd3) ? pio_writedata[3:0] : 4'h0);
        if (pio_chipselect && pio_write_n) begin
            if (pio_address == 2'd3) begin
                pio_readdata <= {28'h0, capture};
                n_edge_rd    <= n_edge_rd + 1;
            end else if (pio_address == 2'd0) begin
                pio_readdata <= {28'h0, in_port};
                n_data_rd    <= n_data_rd + 1;
            end else begin
                pio_readdata <= '0;
            end
        end
        if (pio_chipselect && !pio_write_n) begin
            n_writes <= n_writes + 1;
            last_wd  <= pio_writedata;
        end
    end

    typedef struct {
        logic [3:0] value;
        logic       irq_en;
        logic [3:0] exp_edges;
        logic [3:0] exp_level;
    } vec_t;

    vec_t       vec [4];
    logic [7:0] sb [$];
    int         passed = 0, total = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_busy(input logic val, input int budget, input string name);
        int n = 0;
        while (busy !== val && n < budget) begin
            tick();
            n++;
        end
        if (busy !== val) begin
            total++;
            $display("FAIL %s: busy=%0b after %0d cycles, expected %0b", name, busy, n, val);
        end
    endtask

    task automatic wait_poll_end(input string name);
        wait_busy(1'b1, 4 * POLL_DIV, name);
        wait_busy(1'b0, 16, name);
    endtask

    function automatic logic bus_is(input int sel);
        case (sel)
            0:       return pio_chipselect && pio_write_n && pio_address == 2'd3;
            1:       return pio_chipselect && !pio_write_n && pio_address == 2'd3;
            default: return pio_chipselect && pio_write_n && pio_address == 2'd0;
        endcase
    endfunction

    task automatic wait_bus(input int sel, input string name);
        int n = 0;
        while (!bus_is(sel) && n < 4 * POLL_DIV) begin
            tick();
            n++;
        end
        if (!bus_is(sel)) begin
            total++;
            $display("FAIL %s: bus phase %0d not seen within %0d cycles", name, sel, n);
        end
    endtask

    task automatic pop_check(input string name);
        logic [7:0] e;
        if (sb.size() == 0) begin
            total++;
            $display("FAIL %s: scoreboard empty, got valid=%0b", name, evt_valid);
        end else begin
            e = sb.pop_front();
            check(name, {evt_valid, evt_edges, evt_level}, {1'b1, e});
        end
        evt_pop = 1'b1;
        tick();
        evt_pop = 1'b0;
    endtask

    initial begin
        int         n;
        int         s_wr, s_er, s_dr;
        logic [3:0] cur;
        logic [3:0] ov_vals [5];
        logic [7:0] exp_evt;
        logic       exp_ovf;

        vec[0] = '{4'b0101, 1'b1, 4'b0101, 4'b0101};
        vec[1] = '{4'b0110, 1'b0, 4'b0011, 4'b0110};
        vec[2] = '{4'b1110, 1'b1, 4'b1000, 4'b1110};
        vec[3] = '{4'b0000, 1'b1, 4'b1110, 4'b0000};

        reset = 1'b1; enable = 1'b1; irq_en = 1'b1; evt_pop = 1'b0; ovf_clr = 1'b0;
        repeat (3) tick();
        check("rst_cs", pio_chipselect, 0);
        check("rst_write_n", pio_write_n, 1);
        check("rst_addr", pio_address, 0);
        check("rst_wdata", pio_writedata, 0);
        check("rst_fifo", {evt_valid, evt_edges, evt_level, evt_count}, 0);
        check("rst_flags", {overflow, irq, busy}, 0);
        reset = 1'b0;
        n = 0;
        while (!busy && n < 100) begin
            tick();
            n++;
        end
        check("first_poll_delay", n, POLL_DIV);
        wait_busy(1'b0, 16, "first_poll_end");

        // Table of single-edge events, one per poll period.
        for (int i = 0; i < 4; i++) begin
            irq_en  = vec[i].irq_en;
            in_port = vec[i].value;
            sb.push_back({vec[i].exp_edges, vec[i].exp_level});
            s_wr = n_writes;
            wait_poll_end("vec_poll");
            check("vec_count", evt_count, 1);
            check("vec_irq", irq, vec[i].irq_en);
            check("vec_nwrites", n_writes - s_wr, 1);
            check("vec_wdata", last_wd, vec[i].exp_edges);
            pop_check("vec_head");
            check("vec_empty", {evt_valid, irq}, 0);
        end
        irq_en = 1'b1;

        // Static input: edge reads only.
        s_wr = n_writes; s_er = n_edge_rd; s_dr = n_data_rd;
        for (int i = 0; i < 10; i++) wait_poll_end("idle_poll");
        check("idle_edge_reads", n_edge_rd - s_er, 10);
        check("idle_data_reads", n_data_rd - s_dr, 0);
        check("idle_writes", n_writes - s_wr, 0);
        check("idle_count", evt_count, 0);

        // Partial clear: bit 2 toggles while the edge read is in flight.
        in_port = 4'b0001;
        sb.push_back({4'b0001, 4'b0101});
        wait_bus(0, "pc_rd_edge");
        tick();
        in_port = 4'b0101;
        wait_busy(1'b0, 16, "pc_poll1");
        check("pc_wdata", last_wd, 32'h1);
        sb.push_back({4'b0100, 4'b0101});
        wait_poll_end("pc_poll2");
        check("pc_count", evt_count, 2);
        pop_check("pc_head1");
        pop_check("pc_head2");

        // Overflow: five events into a four-deep FIFO.
        cur = in_port; exp_ovf = 1'b0;
        ov_vals[0] = 4'b0100; ov_vals[1] = 4'b0110; ov_vals[2] = 4'b1110;
        ov_vals[3] = 4'b1111; ov_vals[4] = 4'b0111;
        for (int i = 0; i < 5; i++) begin
            in_port = ov_vals[i];
            if (sb.size() < FIFO_DEPTH) sb.push_back({cur ^ ov_vals[i], ov_vals[i]});
            else exp_ovf = 1'b1;
            cur = ov_vals[i];
            wait_poll_end("ovf_poll");
        end
        check("ovf_count", evt_count, FIFO_DEPTH);
        check("ovf_flag", overflow, exp_ovf);
        check("ovf_head", {evt_edges, evt_level}, sb[0]);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", overflow, 0);

        // Pop exactly in the PUSH cycle while full.
        in_port = 4'b0011;
        exp_evt = {cur ^ 4'b0011, 4'b0011};
        cur = 4'b0011;
        wait_bus(2, "pp_rd_data");
        tick();
        tick();
        exp_evt = exp_evt;
        check("pp_head", {evt_edges, evt_level}, sb[0]);
        void'(sb.pop_front());
        evt_pop = 1'b1;
        tick();
        evt_pop = 1'b0;
        sb.push_back(exp_evt);
        check("pp_count", evt_count, FIFO_DEPTH);
        check("pp_ovf", overflow, 0);
        check("pp_busy", busy, 0);
        for (int i = 0; i < FIFO_DEPTH; i++) pop_check("pp_drain");
        check("pp_empty", evt_count, 0);

        // Enable gating.
        enable = 1'b0;
        in_port = 4'b1011;
        sb.push_back({cur ^ 4'b1011, 4'b1011});
        cur = 4'b1011;
        s_wr = n_writes; s_er = n_edge_rd; s_dr = n_data_rd;
        repeat (4 * POLL_DIV) tick();
        check("dis_accesses", (n_writes - s_wr) + (n_edge_rd - s_er) + (n_data_rd - s_dr), 0);
        check("dis_busy", busy, 0);
        enable = 1'b1;
        wait_poll_end("en_poll");
        check("en_count", evt_count, 1);
        pop_check("en_head");

        // Enable drops mid-poll; the poll still completes.
        in_port = 4'b1010;
        sb.push_back({cur ^ 4'b1010, 4'b1010});
        cur = 4'b1010;
        wait_bus(2, "drop_rd_data");
        enable = 1'b0;
        wait_busy(1'b0, 16, "drop_poll");
        check("drop_count", evt_count, 1);
        pop_check("drop_head");
        enable = 1'b1;

        // Reset during the CLR write.
        in_port = 4'b0010;
        exp_evt = {cur ^ 4'b0010, 4'b0010};
        wait_bus(1, "rc_clr");
        #1 reset = 1'b1;
        #1;
        check("rc_cs_async", {pio_chipselect, pio_write_n}, 2'b01);
        check("rc_state", {busy, evt_valid, evt_count, overflow, irq}, 0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        n = 0;
        while (!busy && n < 100) begin
            tick();
            n++;
        end
        check("rc_first_poll", n, POLL_DIV);
        sb.delete();
        sb.push_back(exp_evt);
        wait_busy(1'b0, 16, "rc_poll");
        check("rc_count", evt_count, 1);
        pop_check("rc_head");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/niosv_soc_gpi_event_poller.md
# niosv_soc_gpi_event_poller

Autonomous poll-and-queue controller for a 4-bit edge-capturing GPI port (e.g. the DIP-switch GPI) on the NIOSV_SOC.
- Periodically reads the GPI edge-capture register over the GPI's Avalon-MM slave port.
- Clears exactly the captured bits and samples the live input level.
- Pushes an {edges, level} event into a small show-ahead FIFO and raises an interrupt while events are pending.
- Relieves the CPU of polling and keeps edge history that would otherwise merge in the sticky capture register.

## Interface
Parameters:
- W, 4, GPI width in bits; 1..32.
- POLL_DIV, 1000, clock cycles between poll starts; ≥8.
- FIFO_DEPTH, 4, event FIFO entries; power of 2, ≥2.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  polling enable; sampled only in IDLE.
- irq_en  in  1  interrupt enable.
- pio_address  out  2  GPI slave address: 0 = data, 3 = edge capture.
- pio_chipselect  out  1  GPI slave select.
- pio_write_n  out  1  GPI write strobe, active-low.
- pio_writedata  out  32  GPI write data; bits [31:W] are always 0.
- pio_readdata  in  32  GPI read data; registered by the slave, valid the cycle after the address is presented.
- evt_pop  in  1  consumer pop; ignored when evt_valid=0.
- evt_valid  out  1  FIFO not empty.
- evt_edges  out  W  head entry, captured edge bits.
- evt_level  out  W  head entry, input level.
- evt_count  out  $clog2(FIFO_DEPTH)+1  entries stored.
- overflow  out  1  sticky: an event was dropped.
- ovf_clr  in  1  clears overflow.
- irq  out  1  evt_valid & irq_en; combinational.
- busy  out  1  state ≠ IDLE.

## Operation
- Poll timer: down-counter, reset to POLL_DIV-1.
  - Decrements every cycle and wraps to POLL_DIV-1 after reaching 0.
  - Counter = 0 with state = IDLE and enable = 1 starts a poll.
  - Counter = 0 in any other condition skips that tick; ticks are not queued.
- FSM states:
  - IDLE: bus idle (chipselect=0, write_n=1, address=0).
  - RD_EDGE: address=3, chipselect=1, write_n=1.
  - WAIT_EDGE: bus idle; captures edges = pio_readdata[W-1:0] at the end of the cycle.
    - edges = 0: go to IDLE; no write, no push.
    - Otherwise: go to CLR.
  - CLR: address=3, chipselect=1, write_n=0, writedata=edges. Clears only the read bits; edges arriving on other bits stay captured.
  - RD_DATA: address=0, chipselect=1, write_n=1.
  - WAIT_DATA: bus idle; captures level = pio_readdata[W-1:0].
  - PUSH: pushes {edges, level}, then goes to IDLE.
- Once started, a poll always completes, even if enable drops.
- FIFO:
  - Show-ahead: evt_edges/evt_level present the head entry whenever evt_valid=1.
  - Pop takes effect at the clock edge.
  - Push while full without a pop in the same cycle: entry dropped, overflow set.
  - Push and pop in the same cycle while full: both occur, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: push only; the pop is ignored.
- overflow: set has priority over ovf_clr in the same cycle.
- Pointers wrap modulo FIFO_DEPTH. evt_count ranges 0..FIFO_DEPTH.
- Known GPI race: an edge on bit k arriving in the CLR cycle is lost when edges[k]=1. This is the GPI's clear-priority behaviour and is accepted.

## Timing
- Reset (async assert, sync release) gives:
  - state=IDLE, chipselect=0, write_n=1, address=0, writedata=0.
  - FIFO empty: evt_valid=0, evt_edges=0, evt_level=0, evt_count=0.
  - overflow=0, irq=0, busy=0, timer=POLL_DIV-1.
- Reset mid-poll: bus strobes deassert immediately (asynchronously). A write in flight is abandoned; the GPI keeps its capture bits.
- Poll durations:
  - Non-empty poll: 6 cycles (RD_EDGE..PUSH). evt_valid rises the cycle after PUSH.
  - Empty poll: 2 cycles.
- Worst-case pin-to-irq latency: GPI sync (3) + POLL_DIV + 7 cycles.
- Bus access is single-cycle with no waitrequest. Every read holds the bus exactly one cycle, followed by one idle WAIT cycle.

## Test plan
- Reset/idle: assert reset mid-CLR. Required: chipselect=0 within the cycle; all outputs hold their reset values; the first poll starts POLL_DIV cycles after reset release.
- Single edge: POLL_DIV=16; toggle in_port 0000→0101. Required:
  - One poll writes 0x5 to address 3.
  - One event with edges=0101, level=0101.
  - irq=1 with irq_en=1; evt_pop returns evt_valid=0 and irq=0.
- No activity: 10 poll periods with a static input. Required: only RD_EDGE/WAIT_EDGE accesses, no writes, evt_count=0.
- Overflow: FIFO_DEPTH=4, 5 distinct toggles in 5 periods, no pops. Required: evt_count=4, overflow=1, head = first event. Then ovf_clr → 0; pop during a full-push keeps count=4 with overflow still 0.
- Partial clear: edge on bit 0 captured; bit 2 edges during WAIT_EDGE. Required: writedata=0x1; the next poll yields edges=0100.
- Enable gating: enable=0 across several ticks. Required: no bus activity. Dropping enable during RD_DATA: the poll completes and its event is pushed.
